// File: rtl/term_pkg.sv
// Shared constants and types for the terminal command engine.
package term_pkg;

  // Control codes recognised by the byte parser
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;

  // Final bytes of escape sequences
  localparam logic [7:0] ESC_UP      = 8'h41;
  localparam logic [7:0] ESC_DOWN    = 8'h42;
  localparam logic [7:0] ESC_RIGHT   = 8'h43;
  localparam logic [7:0] ESC_LEFT    = 8'h44;
  localparam logic [7:0] ESC_HOME    = 8'h48;
  localparam logic [7:0] ESC_CLR_EOS = 8'h4A;
  localparam logic [7:0] ESC_CLR_EOL = 8'h4B;
  localparam logic [7:0] ESC_GOTO    = 8'h59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESCY_ROW,
    ST_ESCY_COL,
    ST_CLEAR
  } parse_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= SPACE) && (b <= TILDE);
  endfunction

endpackage

// File: rtl/term_cmd_engine_if.sv
// Byte stream in, character-buffer / cursor update strobes out.
interface term_cmd_engine_if #(
  parameter int ADDR_BITS = 11,
  parameter int COL_BITS  = 7,
  parameter int ROW_BITS  = 5
);
  logic [7:0]           data;
  logic                 valid;
  logic                 ready;
  logic [7:0]           new_char;
  logic [ADDR_BITS-1:0] new_char_address;
  logic                 new_char_wen;
  logic [ADDR_BITS-1:0] new_first_char;
  logic                 new_first_char_wen;
  logic [COL_BITS-1:0]  new_cursor_x;
  logic [ROW_BITS-1:0]  new_cursor_y;
  logic                 new_cursor_wen;

  modport master (
    output data, valid,
    input  ready, new_char, new_char_address, new_char_wen,
    input  new_first_char, new_first_char_wen,
    input  new_cursor_x, new_cursor_y, new_cursor_wen
  );

  modport slave (
    input  data, valid,
    output ready, new_char, new_char_address, new_char_wen,
    output new_first_char, new_first_char_wen,
    output new_cursor_x, new_cursor_y, new_cursor_wen
  );
endinterface

// File: rtl/term_clear_seq.sv
// Space-fill sequencer: one write per cycle at consecutive wrapping
// addresses. Reset leaves it running a full-screen clear from address 0.
module term_clear_seq
  import term_pkg::*;
#(
  parameter int N         = 2000,
  parameter int ADDR_BITS = 11,
  parameter int CNT_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [CNT_BITS-1:0]  count,
  output logic                 busy,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr
);

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(N - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [CNT_BITS-1:0]  CNT_ALL   = CNT_BITS'(N);
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);

  logic [ADDR_BITS-1:0] addr_q;
  logic [CNT_BITS-1:0]  cnt_q;

  function automatic logic [ADDR_BITS-1:0] addr_step(input logic [ADDR_BITS-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_ONE;
  endfunction

  // Down-counter: the start cycle issues the first write itself, so the
  // remaining count ends on the terminal compare cnt_q == 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b1;
      addr_q  <= '0;
      cnt_q   <= CNT_ALL;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        wr_en   <= 1'b1;
        wr_addr <= start_addr;
        addr_q  <= addr_step(start_addr);
        cnt_q   <= count - CNT_ONE;
        busy    <= (count != CNT_ONE);
      end else if (busy) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_q;
        addr_q  <= addr_step(addr_q);
        cnt_q   <= cnt_q - CNT_ONE;
        busy    <= (cnt_q != CNT_ONE);
      end
    end
  end

endmodule

// File: rtl/term_cmd_engine.sv
// Terminal byte parser: prints characters, moves the cursor, scrolls and
// clears regions of a circular character buffer.
//
//   state       | meaning
//   ST_IDLE     | plain text / control codes
//   ST_ESC      | ESC seen, waiting for command byte
//   ST_ESCY_ROW | ESC Y seen, waiting for row byte
//   ST_ESCY_COL | row captured, waiting for column byte
//   ST_CLEAR    | space-fill in progress, input stalled
module term_cmd_engine
  import term_pkg::*;
#(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11,
  parameter int TAB_STOP  = 8
) (
  input logic               clk,
  input logic               reset,
  term_cmd_engine_if.slave  bus
);

  localparam int N        = ROWS * COLS;
  localparam int CNT_BITS = ADDR_BITS + 1;

  localparam logic [CNT_BITS-1:0] N_C     = CNT_BITS'(N);
  localparam logic [CNT_BITS-1:0] COLS_C  = CNT_BITS'(COLS);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);
  localparam logic [7:0]          COL_MAX8 = 8'(COLS - 1);
  localparam logic [7:0]          ROW_MAX8 = 8'(ROWS - 1);

  parse_state_t          state_q;
  logic [COL_BITS-1:0]   x_q;
  logic [ROW_BITS-1:0]   y_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [ADDR_BITS-1:0]  first_char_q;
  logic [7:0]            char_q;
  logic [ADDR_BITS-1:0]  char_addr_q;
  logic                  char_wen_q;
  logic                  fc_wen_q;
  logic                  cursor_wen_q;
  logic                  clr_pend_q;
  logic [ADDR_BITS-1:0]  pend_addr_q;

  logic                  accept;
  logic                  x_last, y_last;
  logic [CNT_BITS-1:0]   lin;
  logic [CNT_BITS-1:0]   cell_sum;
  logic [ADDR_BITS-1:0]  cell_cur;
  logic [CNT_BITS-1:0]   fc_sum;
  logic [ADDR_BITS-1:0]  fc_next;
  logic [COL_BITS-1:0]   x_left, x_right;
  logic [ROW_BITS-1:0]   y_up, y_down;
  logic [COL_BITS:0]     tab_raw;
  logic [COL_BITS-1:0]   tab_x;
  logic [7:0]            data_off;
  logic [ROW_BITS-1:0]   row_arg;
  logic [COL_BITS-1:0]   col_arg;

  logic                  start_now;
  logic [ADDR_BITS-1:0]  start_addr_now;
  logic [CNT_BITS-1:0]   count_now;
  logic                  clr_start;
  logic [ADDR_BITS-1:0]  clr_addr;
  logic [CNT_BITS-1:0]   clr_count;
  logic                  clr_busy;
  logic                  clr_wen;
  logic [ADDR_BITS-1:0]  clr_waddr;

  assign bus.ready = (state_q != ST_CLEAR);
  assign accept    = bus.valid && bus.ready;

  // Cursor arithmetic: cell address with a single wrap subtraction,
  // saturating moves, tab target and ESC Y argument clamping.
  always_comb begin
    x_last   = (x_q == COL_MAX);
    y_last   = (y_q == ROW_MAX);
    lin      = CNT_BITS'(y_q) * COLS_C + CNT_BITS'(x_q);
    cell_sum = CNT_BITS'(first_char_q) + lin;
    cell_cur = ADDR_BITS'((cell_sum >= N_C) ? cell_sum - N_C : cell_sum);
    fc_sum   = CNT_BITS'(first_char_q) + COLS_C;
    fc_next  = ADDR_BITS'((fc_sum >= N_C) ? fc_sum - N_C : fc_sum);
    x_left   = (x_q == '0) ? x_q : x_q - COL_ONE;
    x_right  = x_last ? x_q : x_q + COL_ONE;
    y_up     = (y_q == '0) ? y_q : y_q - ROW_ONE;
    y_down   = y_last ? y_q : y_q + ROW_ONE;
    tab_raw  = (COL_BITS+1)'((int'(x_q) / TAB_STOP + 1) * TAB_STOP);
    tab_x    = (tab_raw > {1'b0, COL_MAX}) ? COL_MAX : tab_raw[COL_BITS-1:0];
    data_off = bus.data - SPACE;
    if (bus.data < SPACE) begin
      row_arg = '0;
      col_arg = '0;
    end else begin
      row_arg = (data_off > ROW_MAX8) ? ROW_MAX : data_off[ROW_BITS-1:0];
      col_arg = (data_off > COL_MAX8) ? COL_MAX : data_off[COL_BITS-1:0];
    end
  end

  // Clear launch: LF-scroll and ESC J/K start in the accepting cycle so
  // their writes line up with the stall; a bottom-right wrap defers one
  // cycle to keep its character write separate from the fill.
  always_comb begin
    start_now      = 1'b0;
    start_addr_now = cell_cur;
    count_now      = COLS_C;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.data == LF && y_last) begin
            start_now      = 1'b1;
            start_addr_now = first_char_q;
          end
        end
        ST_ESC: begin
          if (bus.data == ESC_CLR_EOS) begin
            start_now = 1'b1;
            count_now = N_C - lin;
          end else if (bus.data == ESC_CLR_EOL) begin
            start_now = 1'b1;
            count_now = COLS_C - CNT_BITS'(x_q);
          end
        end
        default: ;
      endcase
    end
    clr_start = start_now | clr_pend_q;
    clr_addr  = clr_pend_q ? pend_addr_q : start_addr_now;
    clr_count = clr_pend_q ? COLS_C : count_now;
  end

  term_clear_seq #(
    .N         (N),
    .ADDR_BITS (ADDR_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .start      (clr_start),
    .start_addr (clr_addr),
    .count      (clr_count),
    .busy       (clr_busy),
    .wr_en      (clr_wen),
    .wr_addr    (clr_waddr)
  );

  // Parser FSM with registered strobes and cursor/scroll state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      first_char_q <= '0;
      char_q       <= '0;
      char_addr_q  <= '0;
      char_wen_q   <= 1'b0;
      fc_wen_q     <= 1'b0;
      cursor_wen_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      char_wen_q   <= 1'b0;
      fc_wen_q     <= 1'b0;
      cursor_wen_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_printable(bus.data)) begin
              char_q       <= bus.data;
              char_addr_q  <= cell_cur;
              char_wen_q   <= 1'b1;
              cursor_wen_q <= 1'b1;
              if (!x_last) begin
                x_q <= x_q + COL_ONE;
              end else begin
                x_q <= '0;
                if (!y_last) begin
                  y_q <= y_q + ROW_ONE;
                end else begin
                  first_char_q <= fc_next;
                  fc_wen_q     <= 1'b1;
                  clr_pend_q   <= 1'b1;
                  pend_addr_q  <= first_char_q;
                  state_q      <= ST_CLEAR;
                end
              end
            end else begin
              case (bus.data)
                LF: begin
                  if (!y_last) begin
                    y_q          <= y_q + ROW_ONE;
                    cursor_wen_q <= 1'b1;
                  end else begin
                    first_char_q <= fc_next;
                    fc_wen_q     <= 1'b1;
                    state_q      <= ST_CLEAR;
                  end
                end
                CR: begin
                  x_q          <= '0;
                  cursor_wen_q <= (x_q != '0);
                end
                BS: begin
                  x_q          <= x_left;
                  cursor_wen_q <= (x_q != '0);
                end
                TAB: begin
                  x_q          <= tab_x;
                  cursor_wen_q <= (tab_x != x_q);
                end
                ESC:     state_q <= ST_ESC;
                default: ;
              endcase
            end
          end
        end
        ST_ESC: begin
          if (accept) begin
            state_q <= ST_IDLE;
            case (bus.data)
              ESC_UP: begin
                y_q          <= y_up;
                cursor_wen_q <= (y_q != '0);
              end
              ESC_DOWN: begin
                y_q          <= y_down;
                cursor_wen_q <= !y_last;
              end
              ESC_RIGHT: begin
                x_q          <= x_right;
                cursor_wen_q <= !x_last;
              end
              ESC_LEFT: begin
                x_q          <= x_left;
                cursor_wen_q <= (x_q != '0);
              end
              ESC_HOME: begin
                x_q          <= '0;
                y_q          <= '0;
                cursor_wen_q <= (x_q != '0) || (y_q != '0);
              end
              ESC_CLR_EOS, ESC_CLR_EOL: state_q <= ST_CLEAR;
              ESC_GOTO:                 state_q <= ST_ESCY_ROW;
              ESC:                      state_q <= ST_ESC;
              default: ;
            endcase
          end
        end
        ST_ESCY_ROW: begin
          if (accept) begin
            row_q   <= row_arg;
            state_q <= ST_ESCY_COL;
          end
        end
        ST_ESCY_COL: begin
          if (accept) begin
            x_q          <= col_arg;
            y_q          <= row_q;
            cursor_wen_q <= (col_arg != x_q) || (row_q != y_q);
            state_q      <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (!clr_pend_q && !clr_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.new_char_wen       = char_wen_q | clr_wen;
  assign bus.new_char           = clr_wen ? SPACE : char_q;
  assign bus.new_char_address   = clr_wen ? clr_waddr : char_addr_q;
  assign bus.new_first_char     = first_char_q;
  assign bus.new_first_char_wen = fc_wen_q;
  assign bus.new_cursor_x       = x_q;
  assign bus.new_cursor_y       = y_q;
  assign bus.new_cursor_wen     = cursor_wen_q;

endmodule
